game_state_controller: RTL
==========================

Name: game_state_controller

Overview:
Top-level game-flow sequencer for the graphics path. It generates the 3-bit game state consumed by the graphics mixer and the menu/overlay generator. It steps through MENU -> COUNTDOWN -> GAMEPLAY -> GAME_OVER -> MENU using frame ticks, the start button, and player-defeat flags. It also issues the round-reset pulse to player logic and reports the countdown digit and the winner to the overlay renderer.

Parameters:
FRAMES_PER_COUNT, 60, frames each countdown digit (3, 2, 1) stays displayed; legal range 1..255
GAME_OVER_HOLD_FRAMES, 120, minimum frames in GAME_OVER before a start press is accepted; legal range 0..255
CNT_W, 8, width of the internal frame counter; both parameters above must fit in it

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (end of active video)
start_btn  in  1  start button level, already synchronized/debounced
p1_defeated  in  1  level, player 1 health reached zero
p2_defeated  in  1  level, player 2 health reached zero
current_game_state  out  3  000=MENU, 001=COUNTDOWN, 010=GAMEPLAY, 011=GAME_OVER
countdown_digit  out  2  3/2/1 during COUNTDOWN, 0 otherwise
winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw; valid in GAME_OVER
round_reset  out  1  one-cycle pulse: reset player positions/health
gameplay_active  out  1  high only in GAMEPLAY

Behaviour:
- All outputs are registered. Decode-from-state outputs (gameplay_active, countdown_digit) may be combinational from registered state.
- Reset values: state=MENU, countdown_digit=0, winner=00, round_reset=0, gameplay_active=0, frame_cnt=0, start_prev=1.
- start_prev resets to 1, so a button held through reset does not start a game.
- Press detection: press = start_btn & ~start_prev. start_prev updates every cycle in every state. A press that is ignored is consumed; it does not queue.
- MENU:
  - On press: next cycle state=COUNTDOWN, digit=3, frame_cnt=0, round_reset=1 for exactly that cycle.
  - Defeat inputs are ignored.
- COUNTDOWN:
  - frame_cnt increments only on frame_tick.
  - On a frame_tick with frame_cnt==FRAMES_PER_COUNT-1: frame_cnt=0. If digit==1, state=GAMEPLAY and digit=0; otherwise digit decrements.
  - Presses and defeat inputs are ignored.
  - Total COUNTDOWN duration is 3*FRAMES_PER_COUNT frame_ticks.
- GAMEPLAY:
  - In any cycle where p1_defeated|p2_defeated=1: next cycle state=GAME_OVER, frame_cnt=0.
  - winner latched at the same time: both defeated -> 11; p2 only -> 01; p1 only -> 10.
  - frame_tick and presses have no effect.
- GAME_OVER:
  - On frame_tick, frame_cnt increments and saturates at GAME_OVER_HOLD_FRAMES.
  - A press is accepted only when frame_cnt==GAME_OVER_HOLD_FRAMES. With GAME_OVER_HOLD_FRAMES=0 it is accepted immediately.
  - On an accepted press: next cycle state=MENU, winner=00, frame_cnt=0.
  - winner holds constant throughout GAME_OVER.
- Simultaneous events:
  - A frame_tick in the same cycle as a state transition is consumed by the transition; it does not count in the new state.
  - Defeat and press in the same GAMEPLAY cycle -> GAME_OVER; the press is discarded.
- Illegal states (100..111) -> MENU on the next clock, with digit=0 and winner=00.
- rst asserted mid-operation (any state) -> reset values on the next edge. No round_reset pulse is generated by reset.

Test Plan:
1. Reset with start_btn held high, release, press once -> no COUNTDOWN while held through reset. After the press: state=001, digit=3, round_reset high exactly 1 cycle.
2. FRAMES_PER_COUNT=2, press in MENU, apply 6 frame_ticks -> digit 3,3->2,2->1,1->GAMEPLAY. state=010 after the 6th tick; gameplay_active=1; digit=0.
3. In GAMEPLAY drive p2_defeated=1 -> state=011, winner=01. Repeat with p1 only (winner=10) and with both in the same cycle (winner=11).
4. GAME_OVER_HOLD_FRAMES=3: press after 1 tick -> stays 011. After 3 ticks a press -> state=000 and winner=00. Verify frame_cnt saturates with 10 extra ticks.
5. Press during COUNTDOWN, and a defeat during COUNTDOWN/MENU -> no state change. Digit sequence unchanged.
6. Assert rst for 1 cycle during GAMEPLAY and during COUNTDOWN mid-digit -> state=000, all outputs at reset values, no round_reset pulse.

Source files
------------

// File: rtl/game_state_controller.sv
// Game-flow sequencer: MENU -> COUNTDOWN -> GAMEPLAY -> GAME_OVER -> MENU.
// Drives the game state for the graphics mixer, the countdown digit and
// winner for the overlay, and the one-cycle round_reset pulse for player logic.
module game_state_controller #(
  parameter int FRAMES_PER_COUNT      = 60,
  parameter int GAME_OVER_HOLD_FRAMES = 120,
  parameter int CNT_W                 = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       p1_defeated,
  input  logic       p2_defeated,
  output logic [2:0] current_game_state,
  output logic [1:0] countdown_digit,
  output logic [1:0] winner,
  output logic       round_reset,
  output logic       gameplay_active
);

  typedef enum logic [2:0] {
    MENU      = 3'b000,
    COUNTDOWN = 3'b001,
    GAMEPLAY  = 3'b010,
    GAME_OVER = 3'b011
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(FRAMES_PER_COUNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(GAME_OVER_HOLD_FRAMES);

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [1:0]       winner_q, winner_d;
  logic             round_reset_q, round_reset_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             start_prev_q;
  logic             press;

  // Rising edge of the start button; start_prev resets high so a button
  // held through reset is not seen as a press.
  assign press = start_btn & ~start_prev_q;

  // Next-state and next-output decision for every game phase.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    winner_d      = winner_q;
    frame_cnt_d   = frame_cnt_q;
    round_reset_d = 1'b0;
    case (state_q)
      MENU: begin
        if (press) begin
          state_d       = COUNTDOWN;
          digit_d       = 2'd3;
          frame_cnt_d   = '0;
          round_reset_d = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == COUNT_LAST) begin
            frame_cnt_d = '0;
            if (digit_q == 2'd1) begin
              state_d = GAMEPLAY;
              digit_d = 2'd0;
            end else begin
              digit_d = digit_q - 2'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      GAMEPLAY: begin
        // Defeat wins over any press in the same cycle; the press is dropped.
        if (p1_defeated | p2_defeated) begin
          state_d     = GAME_OVER;
          frame_cnt_d = '0;
          // {p1,p2}: p2 only -> 01 (P1 wins), p1 only -> 10, both -> 11.
          winner_d    = {p1_defeated, p2_defeated};
        end
      end
      GAME_OVER: begin
        if (press && (frame_cnt_q == HOLD_LAST)) begin
          state_d     = MENU;
          winner_d    = 2'b00;
          frame_cnt_d = '0;
        end else if (frame_tick && (frame_cnt_q != HOLD_LAST)) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = MENU;
        digit_d     = 2'd0;
        winner_d    = 2'b00;
        frame_cnt_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MENU;
      digit_q       <= 2'd0;
      winner_q      <= 2'b00;
      round_reset_q <= 1'b0;
      frame_cnt_q   <= '0;
      start_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      winner_q      <= winner_d;
      round_reset_q <= round_reset_d;
      frame_cnt_q   <= frame_cnt_d;
      start_prev_q  <= start_btn;
    end
  end

  assign current_game_state = state_q;
  assign countdown_digit    = digit_q;
  assign winner             = winner_q;
  assign round_reset        = round_reset_q;
  assign gameplay_active    = (state_q == GAMEPLAY);

endmodule
